// File: rtl/pq_req_arbiter.sv
// Serialises per-core enqueues and dispatcher dequeues onto the single heap port pair.
// Each core has one holding register; strobes are spaced by a fixed gap counter.
module pq_req_arbiter #(
  parameter int NCORES     = 4,
  parameter int DWIDTH     = 32,
  parameter int GAP_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCORES-1:0]        enq_valid,
  input  logic [NCORES*DWIDTH-1:0] enq_data,
  output logic [NCORES-1:0]        enq_ready,
  input  logic                     deq_req,
  output logic                     deq_ack,
  output logic [DWIDTH-1:0]        deq_data,
  output logic                     pq_enq,
  output logic                     pq_deq,
  output logic [DWIDTH-1:0]        pq_inp_data,
  input  logic [DWIDTH-1:0]        pq_out_data,
  input  logic                     pq_full,
  input  logic                     pq_empty
);

  // state    | meaning
  // ST_ISSUE | decision cycle: pick DEQ, ENQ or nothing
  // ST_WAIT  | strobe issued, gap counter running down to the next decision
  localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int CW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  typedef enum logic {ST_ISSUE, ST_WAIT} state_t;
  typedef enum logic {OP_ENQ, OP_DEQ} op_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CW-1:0]       r_cnt;
  logic [CW-1:0]       w_cnt_nxt;
  logic [NCORES-1:0]   r_held;
  logic [DWIDTH-1:0]   r_hold_data [NCORES];
  logic [PW-1:0]       r_rr_ptr;
  op_t                 r_last_op;
  logic                r_deq_pending;
  logic                r_pq_enq;
  logic                r_pq_deq;
  logic [DWIDTH-1:0]   r_pq_inp_data;
  logic                r_deq_ack;
  logic [DWIDTH-1:0]   r_deq_data;

  logic                w_deq_elig;
  logic                w_enq_elig;
  logic                w_issue_enq;
  logic                w_issue_deq;
  logic [PW-1:0]       w_grant_idx;
  logic                w_grant_found;
  logic [PW:0]         w_scan;
  logic [PW:0]         w_rr_inc;
  logic [PW-1:0]       w_rr_nxt;

  assign w_deq_elig = deq_req && !pq_empty && !r_deq_pending;
  assign w_enq_elig = (|r_held) && !pq_full;

  // Round-robin search: first held core at or after r_rr_ptr, wrapping.
  always_comb begin
    w_grant_idx   = '0;
    w_grant_found = 1'b0;
    w_scan        = '0;
    for (int k = 0; k < NCORES; k++) begin
      w_scan = {1'b0, r_rr_ptr} + (PW+1)'(k);
      if (w_scan >= (PW+1)'(NCORES)) begin
        w_scan = w_scan - (PW+1)'(NCORES);
      end
      if (!w_grant_found && r_held[w_scan[PW-1:0]]) begin
        w_grant_idx   = w_scan[PW-1:0];
        w_grant_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_rr_inc = {1'b0, w_grant_idx} + (PW+1)'(1);
    w_rr_nxt = w_rr_inc[PW-1:0];
    if (w_rr_inc >= (PW+1)'(NCORES)) begin
      w_rr_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ISSUE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // On a tie the op opposite to the previous one wins, giving strict alternation.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_issue_enq = 1'b0;
    w_issue_deq = 1'b0;
    case (r_state)
      ST_ISSUE: begin
        if (w_deq_elig && (!w_enq_elig || (r_last_op == OP_ENQ))) begin
          w_issue_deq = 1'b1;
        end else if (w_enq_elig) begin
          w_issue_enq = 1'b1;
        end
        if (w_issue_enq || w_issue_deq) begin
          w_state_nxt = ST_WAIT;
          w_cnt_nxt   = CW'(GAP_CYCLES);
        end
      end
      ST_WAIT: begin
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_state_nxt = ST_ISSUE;
        end
      end
      default: begin
        w_state_nxt = ST_ISSUE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_held        <= '0;
      r_rr_ptr      <= '0;
      r_last_op     <= OP_ENQ;
      r_deq_pending <= 1'b0;
      r_pq_enq      <= 1'b0;
      r_pq_deq      <= 1'b0;
      r_pq_inp_data <= '0;
      r_deq_ack     <= 1'b0;
      r_deq_data    <= '0;
      for (int i = 0; i < NCORES; i++) begin
        r_hold_data[i] <= '0;
      end
    end else begin
      r_pq_enq  <= w_issue_enq;
      r_pq_deq  <= w_issue_deq;
      r_deq_ack <= r_pq_deq;
      if (r_pq_deq) begin
        r_deq_data <= pq_out_data;
      end
      if (w_issue_enq) begin
        r_pq_inp_data <= r_hold_data[w_grant_idx];
        r_rr_ptr      <= w_rr_nxt;
        r_last_op     <= OP_ENQ;
      end
      if (w_issue_deq) begin
        r_last_op     <= OP_DEQ;
        r_deq_pending <= 1'b1;
      end else if (r_deq_ack) begin
        r_deq_pending <= 1'b0;
      end
      // A granted slot reads as not-ready this cycle, so a same-cycle valid waits one cycle.
      for (int i = 0; i < NCORES; i++) begin
        if (w_issue_enq && (w_grant_idx == PW'(i))) begin
          r_held[i] <= 1'b0;
        end else if (enq_valid[i] && !r_held[i]) begin
          r_held[i]      <= 1'b1;
          r_hold_data[i] <= enq_data[i*DWIDTH +: DWIDTH];
        end
      end
    end
  end

  assign enq_ready   = ~r_held;
  assign deq_ack     = r_deq_ack;
  assign deq_data    = r_deq_data;
  assign pq_enq      = r_pq_enq;
  assign pq_deq      = r_pq_deq;
  assign pq_inp_data = r_pq_inp_data;

endmodule

// File: tb/tb_pq_req_arbiter.sv
// Bench for pq_req_arbiter: a sorted-queue heap stands in for pheap, directed
// scenarios cover the main behaviours and a random run is checked against a cycle model.
module tb_pq_req_arbiter;

  localparam int NC  = 4;
  localparam int DW  = 32;
  localparam int GAP = 1;
  localparam int CAP = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NC-1:0]    enq_valid = '0;
  logic [NC*DW-1:0] enq_data = '0;
  logic [NC-1:0]    enq_ready;
  logic             deq_req = 1'b0;
  logic             deq_ack;
  logic [DW-1:0]    deq_data;
  logic             pq_enq;
  logic             pq_deq;
  logic [DW-1:0]    pq_inp_data;
  logic [DW-1:0]    pq_out_data;
  logic             pq_full;
  logic             pq_empty;

  int n_cmp = 0;
  int n_err = 0;

  pq_req_arbiter #(.NCORES(NC), .DWIDTH(DW), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready),
    .deq_req(deq_req), .deq_ack(deq_ack), .deq_data(deq_data),
    .pq_enq(pq_enq), .pq_deq(pq_deq), .pq_inp_data(pq_inp_data),
    .pq_out_data(pq_out_data), .pq_full(pq_full), .pq_empty(pq_empty)
  );

  always #5 clk = ~clk;

  // Heap stand-in: ascending queue, head is the minimum, flags registered.
  logic [DW-1:0] heap_q[$];
  logic [DW-1:0] h_out = '0;
  logic          h_empty = 1'b1;
  logic          h_full = 1'b0;
  logic          force_full = 1'b0;
  int            hp_pos;

  assign pq_out_data = h_out;
  assign pq_empty    = h_empty;
  assign pq_full     = h_full | force_full;

  always @(posedge clk) begin
    if (rst) begin
      heap_q.delete();
    end else if (pq_enq) begin
      hp_pos = 0;
      while (hp_pos < heap_q.size() && heap_q[hp_pos] <= pq_inp_data) hp_pos++;
      heap_q.insert(hp_pos, pq_inp_data);
    end else if (pq_deq && heap_q.size() > 0) begin
      void'(heap_q.pop_front());
    end
    h_out   <= (heap_q.size() > 0) ? heap_q[0] : '0;
    h_empty <= (heap_q.size() == 0);
    h_full  <= (heap_q.size() >= CAP);
  end

  logic [DW-1:0] exp_w [4];

  // Cycle model state for the random run.
  bit            m_held [NC];
  logic [DW-1:0] m_hdata [NC];
  int            m_rr, m_wait;
  bit            m_last_deq, m_pend, m_enq, m_deq, m_ack;
  logic [DW-1:0] m_inp, m_ddata;

  task automatic set_core(input int i, input logic [DW-1:0] d);
    enq_valid[i] = 1'b1;
    enq_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    enq_valid = '0;
    enq_data = '0;
    deq_req = 1'b0;
    force_full = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pq_enq !== 1'b0) begin n_err++; $display("FAIL reset_pq_enq: got %0b want 0", pq_enq); end
    n_cmp++; if (pq_deq !== 1'b0) begin n_err++; $display("FAIL reset_pq_deq: got %0b want 0", pq_deq); end
    n_cmp++; if (pq_inp_data !== '0) begin n_err++; $display("FAIL reset_inp_data: got %0h want 0", pq_inp_data); end
    n_cmp++; if (deq_ack !== 1'b0) begin n_err++; $display("FAIL reset_deq_ack: got %0b want 0", deq_ack); end
    n_cmp++; if (deq_data !== '0) begin n_err++; $display("FAIL reset_deq_data: got %0h want 0", deq_data); end
    n_cmp++; if (enq_ready !== 4'hF) begin n_err++; $display("FAIL reset_enq_ready: got %0h want f", enq_ready); end
  endtask

  task automatic test_single_enq();
    do_reset();
    set_core(0, 32'h64);
    @(negedge clk);
    enq_valid = '0;
    n_cmp++; if (enq_ready[0] !== 1'b0) begin n_err++; $display("FAIL single_ready_low: got %0b want 0", enq_ready[0]); end
    n_cmp++; if (pq_enq !== 1'b0) begin n_err++; $display("FAIL single_early_strobe: got %0b want 0", pq_enq); end
    @(negedge clk);
    n_cmp++; if (pq_enq !== 1'b1) begin n_err++; $display("FAIL single_strobe: got %0b want 1", pq_enq); end
    n_cmp++; if (pq_inp_data !== 32'h64) begin n_err++; $display("FAIL single_data: got %0h want 64", pq_inp_data); end
    n_cmp++; if (enq_ready[0] !== 1'b1) begin n_err++; $display("FAIL single_ready_back: got %0b want 1", enq_ready[0]); end
    @(negedge clk);
    n_cmp++; if (pq_enq !== 1'b0) begin n_err++; $display("FAIL single_one_cycle: got %0b want 0", pq_enq); end
  endtask

  task automatic test_multi_enq();
    int seen;
    seen = 0;
    exp_w[0] = 32'h40; exp_w[1] = 32'h30; exp_w[2] = 32'h20; exp_w[3] = 32'h10;
    do_reset();
    for (int i = 0; i < 4; i++) set_core(i, exp_w[i]);
    @(negedge clk);
    enq_valid = '0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (pq_enq) begin
        n_cmp++; if (cyc !== 2 + 2*seen) begin n_err++; $display("FAIL multi_spacing: strobe %0d at cycle %0d want %0d", seen, cyc, 2 + 2*seen); end
        if (seen < 4) begin
          n_cmp++; if (pq_inp_data !== exp_w[seen]) begin n_err++; $display("FAIL multi_order: strobe %0d got %0h want %0h", seen, pq_inp_data, exp_w[seen]); end
        end
        seen++;
      end
      @(negedge clk);
    end
    n_cmp++; if (seen !== 4) begin n_err++; $display("FAIL multi_count: got %0d strobes want 4", seen); end
    n_cmp++; if (enq_ready !== 4'hF) begin n_err++; $display("FAIL multi_ready: got %0h want f", enq_ready); end
  endtask

  task automatic test_deq();
    int lat;
    bit got;
    do_reset();
    set_core(0, 32'd9);
    set_core(1, 32'd5);
    @(negedge clk);
    enq_valid = '0;
    repeat (5) @(negedge clk);
    deq_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (pq_deq !== 1'b1) begin n_err++; $display("FAIL deq_strobe: got %0b want 1", pq_deq); end
    n_cmp++; if (deq_ack !== 1'b0) begin n_err++; $display("FAIL deq_early_ack: got %0b want 0", deq_ack); end
    @(negedge clk);
    n_cmp++; if (deq_ack !== 1'b1) begin n_err++; $display("FAIL deq_ack1: got %0b want 1", deq_ack); end
    n_cmp++; if (deq_data !== 32'd5) begin n_err++; $display("FAIL deq_data1: got %0d want 5", deq_data); end
    deq_req = 1'b0;
    @(negedge clk);
    n_cmp++; if (deq_ack !== 1'b0) begin n_err++; $display("FAIL deq_ack_pulse: got %0b want 0", deq_ack); end
    deq_req = 1'b1;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (!got && deq_ack) begin
        got = 1'b1;
        lat = k;
        deq_req = 1'b0;
        n_cmp++; if (deq_data !== 32'd9) begin n_err++; $display("FAIL deq_data2: got %0d want 9", deq_data); end
      end
    end
    deq_req = 1'b0;
    n_cmp++; if (!got || lat !== 2) begin n_err++; $display("FAIL deq_latency2: got %0d (ack seen %0b) want 2", lat, got); end
  endtask

  task automatic test_alternate();
    int seq[$];
    logic [DW-1:0] ew[$];
    do_reset();
    set_core(3, 32'h01);
    @(negedge clk);
    enq_valid = '0;
    repeat (2) @(negedge clk);
    set_core(0, 32'h11);
    set_core(1, 32'h22);
    set_core(2, 32'h33);
    deq_req = 1'b1;
    @(negedge clk);
    enq_valid = '0;
    for (int k = 0; k < 14; k++) begin
      n_cmp++; if (pq_enq && pq_deq) begin n_err++; $display("FAIL alt_both_strobes: cycle %0d got enq=1 deq=1 want not both", k); end
      if (pq_deq) seq.push_back(1);
      if (pq_enq) begin seq.push_back(2); ew.push_back(pq_inp_data); end
      @(negedge clk);
    end
    deq_req = 1'b0;
    n_cmp++; if (seq.size() < 6) begin n_err++; $display("FAIL alt_count: got %0d strobes want >=6", seq.size()); end
    for (int k = 0; k < 6 && k < seq.size(); k++) begin
      n_cmp++; if (seq[k] !== ((k % 2 == 0) ? 1 : 2)) begin n_err++; $display("FAIL alt_order: strobe %0d got %0s want %0s", k, (seq[k] == 1) ? "DEQ" : "ENQ", (k % 2 == 0) ? "DEQ" : "ENQ"); end
    end
    n_cmp++; if (ew.size() < 3 || ew[0] !== 32'h11 || ew[1] !== 32'h22 || ew[2] !== 32'h33) begin
      n_err++; $display("FAIL alt_enq_words: got %0d words want 11,22,33 in order", ew.size());
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_stall();
    bit found;
    do_reset();
    force_full = 1'b1;
    deq_req = 1'b1;
    set_core(0, 32'hA1);
    set_core(1, 32'hA2);
    @(negedge clk);
    enq_valid = '0;
    for (int k = 0; k < 20; k++) begin
      n_cmp++; if ({pq_enq, pq_deq} !== 2'b00) begin n_err++; $display("FAIL stall_strobe: cycle %0d got enq=%0b deq=%0b want 0", k, pq_enq, pq_deq); end
      @(negedge clk);
    end
    force_full = 1'b0;
    found = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      if (pq_enq) found = 1'b1;
    end
    deq_req = 1'b0;
    n_cmp++; if (!found) begin n_err++; $display("FAIL stall_release: got no ENQ strobe want one within 2 cycles"); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset_mid_deq();
    do_reset();
    set_core(0, 32'h77);
    @(negedge clk);
    enq_valid = '0;
    repeat (2) @(negedge clk);
    deq_req = 1'b1;
    @(negedge clk);
    n_cmp++; if (pq_deq !== 1'b1) begin n_err++; $display("FAIL rstdeq_strobe: got %0b want 1", pq_deq); end
    rst = 1'b1;
    set_core(2, 32'h55);
    @(negedge clk);
    n_cmp++; if (deq_ack !== 1'b0) begin n_err++; $display("FAIL rstdeq_ack: got %0b want 0", deq_ack); end
    n_cmp++; if ({pq_enq, pq_deq} !== 2'b00) begin n_err++; $display("FAIL rstdeq_strobes: got %0b want 0", {pq_enq, pq_deq}); end
    n_cmp++; if (pq_inp_data !== '0 || deq_data !== '0) begin n_err++; $display("FAIL rstdeq_data: got inp=%0h deq=%0h want 0", pq_inp_data, deq_data); end
    n_cmp++; if (enq_ready !== 4'hF) begin n_err++; $display("FAIL rstdeq_ready: got %0h want f", enq_ready); end
    rst = 1'b0;
    deq_req = 1'b0;
    enq_valid = '0;
    @(negedge clk);
    n_cmp++; if (deq_ack !== 1'b0) begin n_err++; $display("FAIL rstdeq_late_ack: got %0b want 0", deq_ack); end
  endtask

  task automatic test_random();
    bit            disp_req, old_held [NC], any_h, de, ee, f_empty, f_full;
    bit            n_enq, n_deq, n_ack;
    logic [DW-1:0] f_out, d;
    logic [NC-1:0] m_ready;
    int            g;
    do_reset();
    for (int i = 0; i < NC; i++) begin m_held[i] = 0; m_hdata[i] = '0; end
    m_rr = 0; m_wait = 0; m_last_deq = 0; m_pend = 0;
    m_enq = 0; m_deq = 0; m_ack = 0; m_inp = '0; m_ddata = '0;
    disp_req = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < NC; i++) m_ready[i] = !m_held[i];
      n_cmp++; if (pq_enq !== m_enq) begin n_err++; $display("FAIL rnd_pq_enq: cycle %0d got %0b want %0b", cyc, pq_enq, m_enq); end
      n_cmp++; if (pq_deq !== m_deq) begin n_err++; $display("FAIL rnd_pq_deq: cycle %0d got %0b want %0b", cyc, pq_deq, m_deq); end
      n_cmp++; if (pq_inp_data !== m_inp) begin n_err++; $display("FAIL rnd_inp_data: cycle %0d got %0h want %0h", cyc, pq_inp_data, m_inp); end
      n_cmp++; if (deq_ack !== m_ack) begin n_err++; $display("FAIL rnd_deq_ack: cycle %0d got %0b want %0b", cyc, deq_ack, m_ack); end
      n_cmp++; if (deq_data !== m_ddata) begin n_err++; $display("FAIL rnd_deq_data: cycle %0d got %0h want %0h", cyc, deq_data, m_ddata); end
      n_cmp++; if (enq_ready !== m_ready) begin n_err++; $display("FAIL rnd_enq_ready: cycle %0d got %0h want %0h", cyc, enq_ready, m_ready); end
      n_cmp++; if (pq_enq && pq_deq) begin n_err++; $display("FAIL rnd_both_strobes: cycle %0d got both want one", cyc); end

      if (disp_req && m_ack) disp_req = 0;
      else if (!disp_req && $urandom_range(0, 3) == 0) disp_req = 1;
      deq_req = disp_req;
      for (int i = 0; i < NC; i++) begin
        enq_valid[i] = ($urandom_range(0, 2) == 0);
        d = $urandom;
        enq_data[i*DW +: DW] = d;
      end
      f_empty = pq_empty; f_full = pq_full; f_out = pq_out_data;

      for (int i = 0; i < NC; i++) old_held[i] = m_held[i];
      n_enq = 0; n_deq = 0; n_ack = m_deq;
      if (m_deq) m_ddata = f_out;
      if (m_wait == 0) begin
        any_h = 0;
        for (int i = 0; i < NC; i++) any_h |= old_held[i];
        de = disp_req && !f_empty && !m_pend;
        ee = any_h && !f_full;
        if (m_ack) m_pend = 0;
        if (de && (!ee || !m_last_deq)) begin
          n_deq = 1; m_last_deq = 1; m_pend = 1; m_wait = GAP;
        end else if (ee) begin
          g = -1;
          for (int k = 0; k < NC; k++) if (g < 0 && old_held[(m_rr + k) % NC]) g = (m_rr + k) % NC;
          n_enq = 1; m_inp = m_hdata[g]; m_held[g] = 0;
          m_rr = (g + 1) % NC; m_last_deq = 0; m_wait = GAP;
        end
      end else begin
        if (m_ack) m_pend = 0;
        m_wait--;
      end
      for (int i = 0; i < NC; i++) begin
        if (enq_valid[i] && !old_held[i]) begin
          m_held[i] = 1;
          m_hdata[i] = enq_data[i*DW +: DW];
        end
      end
      m_enq = n_enq; m_deq = n_deq; m_ack = n_ack;
      @(negedge clk);
    end
    enq_valid = '0;
    deq_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_enq();
    test_multi_enq();
    test_deq();
    test_alternate();
    test_stall();
    test_reset_mid_deq();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
